// File: rtl/disp_share_ctrl_if.sv
// Requester/display bundle for the shared seven-segment display arbiter.
// master = application requesters side, slave = the arbiter.
interface disp_share_ctrl_if;
    logic        req0;
    logic        req1;
    logic [15:0] data0;
    logic [15:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [3:0]  C;
    logic [3:0]  D;
    logic        owner;
    logic        busy;
    logic        tick;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, A, B, C, D, owner, busy, tick
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, A, B, C, D, owner, busy, tick
    );
endinterface

// File: rtl/disp_share_ctrl.sv
// Round-robin owner arbitration for the 4-digit display mux, with a minimum
// hold time under contention counted in 1 kHz ticks from a free-running prescaler.
module disp_share_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HOLD_TICKS = 1000,
    parameter logic [3:0]  IDLE_CODE  = 4'd10
) (
    input  logic             ck,
    input  logic             R,
    disp_share_ctrl_if.slave bus
);
    localparam int unsigned       HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam logic [15:0]       CNT_LAST = 16'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt, cnt_d;
    logic              tick_q, tick_d;
    logic [HOLD_W-1:0] hold, hold_d;
    logic              last, last_d;
    logic              hold_done;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic [15:0]       frame_q, frame_d;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] frame_for(input state_t s, input logic [15:0] d0,
                                              input logic [15:0] d1);
        case (s)
            ST_OWN0: return d0;
            ST_OWN1: return d1;
            default: return {4{IDLE_CODE}};
        endcase
    endfunction

    always_comb begin
        tick_d    = (cnt == CNT_LAST);
        cnt_d     = tick_d ? 16'd0 : cnt + 16'd1;
        hold_done = (hold == HOLD_MAX);

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) state_d = last ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)        state_d = ST_OWN0;
                else if (bus.req1)        state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (bus.req0) begin
                    if (bus.req1 && hold_done) state_d = ST_OWN1;
                end else begin
                    state_d = bus.req1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (bus.req1) begin
                    if (bus.req0 && hold_done) state_d = ST_OWN0;
                end else begin
                    state_d = bus.req0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any grant change restarts the hold window; a tick on that same edge is dropped.
        last_d = last;
        hold_d = hold;
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d != ST_IDLE) last_d = (state_d == ST_OWN1);
        end else if (state_q != ST_IDLE && tick_q) begin
            hold_d = sat_inc(hold);
        end

        // Outputs decode the next state so grant and digits switch on the same edge.
        gnt0_d  = (state_d == ST_OWN0);
        gnt1_d  = (state_d == ST_OWN1);
        busy_d  = (state_d != ST_IDLE);
        owner_d = (state_d == ST_OWN1);
        frame_d = frame_for(state_d, bus.data0, bus.data1);
    end

    always_ff @(posedge ck) begin
        if (!R) begin
            state_q <= ST_IDLE;
            cnt     <= '0;
            tick_q  <= 1'b0;
            hold    <= '0;
            last    <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            frame_q <= {4{IDLE_CODE}};
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            tick_q  <= tick_d;
            hold    <= hold_d;
            last    <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            frame_q <= frame_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.tick  = tick_q;
    assign bus.A     = frame_q[15:12];
    assign bus.B     = frame_q[11:8];
    assign bus.C     = frame_q[7:4];
    assign bus.D     = frame_q[3:0];
endmodule

// File: tb/tb_disp_share_ctrl.sv
// Scoreboard bench for disp_share_ctrl: stimulus queues expected output frames
// and tick cycles; a negedge monitor pops and compares them.
module tb_disp_share_ctrl;
    logic ck = 1'b0;
    logic R;
    always #5 ck = ~ck;

    disp_share_ctrl_if bus ();

    disp_share_ctrl #(
        .TICK_DIV  (50000),
        .HOLD_TICKS(3),
        .IDLE_CODE (4'd10)
    ) dut (
        .ck (ck),
        .R  (R),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [19:0] vec;
        bit          chk_int;
        logic        last;
        int          hold;
    } exp_t;

    exp_t exp_q[$];
    int   tick_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic push(input string nm, input int at, input logic g0, input logic g1,
                        input logic [15:0] fr, input bit ci, input logic el, input int eh);
        exp_t e;
        e.cyc     = at;
        e.name    = nm;
        e.vec     = {g0, g1, g0 | g1, g1, fr};
        e.chk_int = ci;
        e.last    = el;
        e.hold    = eh;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge ck);
        #2;
    endtask

    // cnt sits at TICK_DIV-5 for the coming edge, so tick is high after the 5th edge.
    task automatic force_tick();
        force dut.cnt = 16'd49995;
        #1;
        release dut.cnt;
        tick_q.push_back(cyc + 5);
    endtask

    always @(negedge ck) begin
        logic [19:0] got;
        int          t;
        exp_t        e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            got = {bus.gnt0, bus.gnt1, bus.busy, bus.owner, bus.A, bus.B, bus.C, bus.D};
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (got !== e.vec) begin
                n_bad++;
                $display("FAIL %s @%0d: {gnt0,gnt1,busy,owner,ABCD} got %h required %h",
                         e.name, cyc, got, e.vec);
            end
            if (e.chk_int) begin
                n_cmp++;
                if (dut.last !== e.last || int'(dut.hold) != e.hold) begin
                    n_bad++;
                    $display("FAIL %s_int @%0d: last/hold got %0d/%0d required %0d/%0d",
                             e.name, cyc, dut.last, int'(dut.hold), e.last, e.hold);
                end
            end
        end
        if (tick_q.size() > 0 && tick_q[0] < cyc) begin
            t = tick_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL tick_missing: no tick at cycle %0d, required one", t);
        end
        if (bus.tick === 1'b1) begin
            n_cmp++;
            if (tick_q.size() == 0) begin
                n_bad++;
                $display("FAIL tick_unexpected: tick at cycle %0d, required none", cyc);
            end else begin
                t = tick_q.pop_front();
                if (t != cyc) begin
                    n_bad++;
                    $display("FAIL tick_cycle: tick at cycle %0d, required cycle %0d", cyc, t);
                end
            end
        end
    end

    initial begin
        int tick_nat;
        R         = 1'b0;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = 16'h0000;
        bus.data1 = 16'h0000;

        // Reset held, then idle with no requests; one accelerated tick.
        for (int i = 0; i < 5; i++) begin
            push("reset_idle", cyc + 1, 1'b0, 1'b0, 16'hAAAA, i == 4, 1'b1, 0);
            step();
        end
        R = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push("post_reset_idle", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
            step();
        end
        force_tick();
        for (int i = 0; i < 6; i++) begin
            push("idle_forced_tick", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
            step();
        end

        // Tie straight after reset: requester 0 first, then hand-off without a gap.
        bus.data0 = 16'h0123;
        bus.data1 = 16'h4567;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        push("tie_reset_gnt0", cyc + 1, 1'b1, 1'b0, 16'h0123, 1'b1, 1'b0, 0);
        step();
        push("tie_keep0", cyc + 1, 1'b1, 1'b0, 16'h0123, 1'b0, 1'b0, 0);
        step();
        bus.req0 = 1'b0;
        push("tie_release_gnt1", cyc + 1, 1'b0, 1'b1, 16'h4567, 1'b1, 1'b1, 0);
        step();
        bus.req1 = 1'b0;
        push("tie_all_released", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
        step();

        // Single requester, live data, release.
        bus.req0  = 1'b1;
        bus.data0 = 16'h953A;
        push("single_grant", cyc + 1, 1'b1, 1'b0, 16'h953A, 1'b0, 1'b0, 0);
        step();
        bus.data0 = 16'h1234;
        push("single_data_follow", cyc + 1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 0);
        step();
        bus.req0 = 1'b0;
        push("single_release", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 0);
        step();

        // Tie with requester 0 served last: requester 1 wins.
        bus.data0 = 16'h0123;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        push("tie_rr_gnt1", cyc + 1, 1'b0, 1'b1, 16'h4567, 1'b0, 1'b0, 0);
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        push("tie_rr_release", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
        step();

        // Hold pre-emption with three ticks each way.
        bus.data0 = 16'h2468;
        bus.data1 = 16'h1357;
        bus.req0  = 1'b1;
        push("hold_grant0", cyc + 1, 1'b1, 1'b0, 16'h2468, 1'b0, 1'b0, 0);
        step();
        bus.req1 = 1'b1;
        push("hold_contend", cyc + 1, 1'b1, 1'b0, 16'h2468, 1'b0, 1'b0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            force_tick();
            for (int j = 0; j < 6; j++) begin
                push("hold_wait0", cyc + 1, 1'b1, 1'b0, 16'h2468, j == 5, 1'b0, k + 1);
                step();
            end
        end
        push("hold_preempt1", cyc + 1, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b1, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            force_tick();
            for (int j = 0; j < 6; j++) begin
                push("hold_wait1", cyc + 1, 1'b0, 1'b1, 16'h1357, j == 5, 1'b1, k + 1);
                step();
            end
        end
        push("hold_return0", cyc + 1, 1'b1, 1'b0, 16'h2468, 1'b1, 1'b0, 0);
        step();

        // Reset while requester 1 owns with hold = 2.
        bus.req0 = 1'b0;
        push("release_to1", cyc + 1, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b1, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            force_tick();
            for (int j = 0; j < 6; j++) begin
                push("mid_hold1", cyc + 1, 1'b0, 1'b1, 16'h1357, j == 5, 1'b1, k + 1);
                step();
            end
        end
        R = 1'b0;
        push("mid_reset", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 0);
        step();
        tick_nat = cyc + 50000;
        tick_q.push_back(tick_nat);
        R        = 1'b1;
        bus.req0 = 1'b1;
        push("post_reset_tie", cyc + 1, 1'b1, 1'b0, 16'h2468, 1'b1, 1'b0, 0);
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        push("final_idle", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
        step();

        // Free-running period: next tick exactly TICK_DIV cycles after reset.
        while (cyc < tick_nat + 3) step();
        push("end_idle", cyc + 1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0);
        step();
        step();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, required at cycle %0d", e.name, e.cyc);
        end
        while (tick_q.size() > 0) begin
            int t;
            t = tick_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL tick_missing: no tick seen, required at cycle %0d", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
